// File: rtl/ddr3_pg_pkg.sv
// ddr3_pg_pkg
// Constants and types shared by the page-transfer initiator (ring sequencer)
// and the DDR3 page transfer controller.
//   PG_ADDR_W   : width of a DDR3 app address
//   PG_STRIDE   : app-address units per page (256 beats x 8)
//   REQS_PER_PG : app requests (beats) per page
//   pg_op_t     : transfer direction as carried on pg_optype
//   pg_state_t  : handshake FSM states of the sequencer
//   page_addr() : start address of page idx, modulo the app address width
package ddr3_pg_pkg;

    localparam int PG_ADDR_W   = 28;
    localparam int PG_STRIDE   = 2048;
    localparam int REQS_PER_PG = 256;

    typedef enum logic {
        OPREAD  = 1'b0,
        OPWRITE = 1'b1
    } pg_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_REL,
        S_DONE
    } pg_state_t;

    // Arithmetic is done in PG_ADDR_W bits so the result wraps exactly like
    // the app address bus does.
    function automatic logic [PG_ADDR_W-1:0] page_addr(
        input logic [PG_ADDR_W-1:0] base,
        input logic [PG_ADDR_W-1:0] idx,
        input int                   stride
    );
        return base + idx * PG_ADDR_W'(stride);
    endfunction

endpackage

// File: rtl/ddr3_pg_ring_sequencer_if.sv
// ddr3_pg_ring_sequencer_if
// Page-transfer request/acknowledge handshake between the ring sequencer
// (master) and the DDR3 page transfer controller (slave).
//   pg_req      : master -> slave, request held until pg_ack is seen
//   pg_optype   : master -> slave, 0 = read from DDR3, 1 = write to DDR3
//   pg_req_addr : master -> slave, DDR3 app start address of the page
//   pg_ack      : slave -> master, acknowledge; must be released again
//                 before the master starts another transfer
interface ddr3_pg_ring_sequencer_if;
    import ddr3_pg_pkg::*;

    logic                 pg_req;
    logic                 pg_optype;
    logic [PG_ADDR_W-1:0] pg_req_addr;
    logic                 pg_ack;

    modport master (
        output pg_req,
        output pg_optype,
        output pg_req_addr,
        input  pg_ack
    );

    modport slave (
        input  pg_req,
        input  pg_optype,
        input  pg_req_addr,
        output pg_ack
    );

endinterface

// File: rtl/pg_ring_ptr.sv
// pg_ring_ptr
// Ring index counter: advances by one on inc and wraps from N-1 back to 0.
// The wrap is explicit so N need not be a power of two.
//   clk : clock
//   rst : synchronous active-high reset, index returns to 0
//   inc : advance the index this cycle
//   ptr : current index, 0 .. N-1
module pg_ring_ptr #(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_reg;
    logic [W-1:0] ptr_next;

    always_comb begin
        ptr_next = ptr_reg;
        if (inc) begin
            ptr_next = (ptr_reg == W'(N - 1)) ? '0 : ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/ddr3_pg_ring_sequencer.sv
// ddr3_pg_ring_sequencer
// Initiator side of the DDR3 page-transfer handshake. DDR3 is managed as a
// ring of N_PAGES fixed-size pages: producer "page ready" pulses become page
// writes at wr_ptr, consumer "page wanted" pulses become page reads at rd_ptr.
//   clk, rst            : clock, synchronous active-high reset
//   wr_pg_req           : 1-cycle pulse, DPRAM holds a page to store
//   rd_pg_req           : 1-cycle pulse, consumer wants the oldest page
//   clear_err           : clears the sticky error flags
//   pg                  : request/ack handshake to the transfer controller
//   wr_pg_done          : 1-cycle pulse, a page write completed
//   rd_pg_done          : 1-cycle pulse, a page read completed
//   busy                : handshake FSM is not idle
//   pg_count            : pages currently stored in the ring
//   full, empty         : pg_count == N_PAGES, pg_count == 0
//   wr_drop_err         : sticky, a write pulse arrived while one was pending
//   rd_drop_err         : sticky, a read pulse arrived while one was pending
//   timeout_err         : sticky, pg_ack took ACK_TIMEOUT cycles or more
module ddr3_pg_ring_sequencer
    import ddr3_pg_pkg::*;
#(
    parameter int                   N_PAGES        = 16,
    parameter logic [PG_ADDR_W-1:0] BASE_ADDR      = 28'h0,
    parameter int                   PG_ADDR_STRIDE = PG_STRIDE,
    parameter int                   ACK_TIMEOUT    = 65535,
    localparam int                  PTR_W          = $clog2(N_PAGES),
    localparam int                  CNT_W          = $clog2(N_PAGES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_pg_req,
    input  logic                       rd_pg_req,
    input  logic                       clear_err,
    ddr3_pg_ring_sequencer_if.master   pg,
    output logic                       wr_pg_done,
    output logic                       rd_pg_done,
    output logic                       busy,
    output logic [CNT_W-1:0]           pg_count,
    output logic                       full,
    output logic                       empty,
    output logic                       wr_drop_err,
    output logic                       rd_drop_err,
    output logic                       timeout_err
);

    localparam int WR_IDX = 0;
    localparam int RD_IDX = 1;

    // ---------------------------------------------------------------
    // Ring pointers: index WR_IDX is the write pointer, RD_IDX the read one
    // ---------------------------------------------------------------
    logic [PTR_W-1:0] ptr_val [2];
    logic [1:0]       ptr_inc;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ptr
            pg_ring_ptr #(
                .N (N_PAGES),
                .W (PTR_W)
            ) u_ptr (
                .clk (clk),
                .rst (rst),
                .inc (ptr_inc[gi]),
                .ptr (ptr_val[gi])
            );
        end
    endgenerate

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    pg_state_t            state_reg,      state_next;
    logic                 pg_req_reg,     pg_req_next;
    pg_op_t               optype_reg,     optype_next;
    logic [PG_ADDR_W-1:0] addr_reg,       addr_next;
    pg_op_t               last_op_reg,    last_op_next;
    logic [CNT_W-1:0]     count_reg,      count_next;
    logic                 wr_done_reg,    wr_done_next;
    logic                 rd_done_reg,    rd_done_next;
    logic                 wr_pending_reg, wr_pending_next;
    logic                 rd_pending_reg, rd_pending_next;
    logic                 wr_drop_reg,    wr_drop_next;
    logic                 rd_drop_reg,    rd_drop_next;
    logic                 tmo_err_reg,    tmo_err_next;
    logic [31:0]          tmo_cnt_reg,    tmo_cnt_next;

    logic wr_elig;
    logic rd_elig;
    logic choose_wr;
    logic wr_take;
    logic rd_take;
    logic in_handshake;

    assign wr_elig = wr_pending_reg && (count_reg < CNT_W'(N_PAGES));
    assign rd_elig = rd_pending_reg && (count_reg != '0);

    // With both eligible, alternate away from the last completed operation.
    assign choose_wr = wr_elig && (!rd_elig || (last_op_reg == OPREAD));

    assign in_handshake = (state_reg == S_REQ) || (state_reg == S_REL);

    // ---------------------------------------------------------------
    // Handshake FSM, next state and registered outputs
    // ---------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        pg_req_next  = pg_req_reg;
        optype_next  = optype_reg;
        addr_next    = addr_reg;
        last_op_next = last_op_reg;
        count_next   = count_reg;
        wr_done_next = 1'b0;
        rd_done_next = 1'b0;
        wr_take      = 1'b0;
        rd_take      = 1'b0;
        ptr_inc      = '0;

        case (state_reg)
            S_IDLE: begin
                if (wr_elig || rd_elig) begin
                    pg_req_next = 1'b1;
                    state_next  = S_REQ;
                    if (choose_wr) begin
                        wr_take     = 1'b1;
                        optype_next = OPWRITE;
                        addr_next   = page_addr(BASE_ADDR, PG_ADDR_W'(ptr_val[WR_IDX]),
                                                PG_ADDR_STRIDE);
                    end else begin
                        rd_take     = 1'b1;
                        optype_next = OPREAD;
                        addr_next   = page_addr(BASE_ADDR, PG_ADDR_W'(ptr_val[RD_IDX]),
                                                PG_ADDR_STRIDE);
                    end
                end
            end

            S_REQ: begin
                if (pg.pg_ack) begin
                    pg_req_next = 1'b0;
                    state_next  = S_REL;
                end
            end

            S_REL: begin
                // The controller must drop its ack before the page counts as
                // transferred, so back-to-back requests never see a stale ack.
                if (!pg.pg_ack) begin
                    state_next = S_DONE;
                end
            end

            S_DONE: begin
                if (optype_reg == OPWRITE) begin
                    ptr_inc[WR_IDX] = 1'b1;
                    count_next      = count_reg + 1'b1;
                    wr_done_next    = 1'b1;
                end else begin
                    ptr_inc[RD_IDX] = 1'b1;
                    count_next      = count_reg - 1'b1;
                    rd_done_next    = 1'b1;
                end
                last_op_next = optype_reg;
                state_next   = S_IDLE;
            end

            default: begin
                state_next  = S_IDLE;
                pg_req_next = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Pending requests, sticky errors, ack timeout
    // ---------------------------------------------------------------
    always_comb begin
        // A pulse on the very cycle its pending bit is consumed is a fresh
        // request, not a drop.
        wr_pending_next = wr_pg_req || (wr_pending_reg && !wr_take);
        rd_pending_next = rd_pg_req || (rd_pending_reg && !rd_take);

        // A new error event outranks clear_err on the same cycle.
        wr_drop_next = (wr_pg_req && wr_pending_reg && !wr_take) ? 1'b1 :
                       (clear_err ? 1'b0 : wr_drop_reg);
        rd_drop_next = (rd_pg_req && rd_pending_reg && !rd_take) ? 1'b1 :
                       (clear_err ? 1'b0 : rd_drop_reg);

        tmo_err_next = (in_handshake && (tmo_cnt_reg == 32'(ACK_TIMEOUT))) ? 1'b1 :
                       (clear_err ? 1'b0 : tmo_err_reg);

        // Counts cycles spent in the current handshake state and saturates,
        // so a stuck controller cannot wrap it back below the threshold.
        tmo_cnt_next = tmo_cnt_reg;
        if (state_next != state_reg) begin
            tmo_cnt_next = '0;
        end else if (in_handshake && (tmo_cnt_reg != 32'(ACK_TIMEOUT))) begin
            tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            pg_req_reg     <= 1'b0;
            optype_reg     <= OPREAD;
            addr_reg       <= '0;
            last_op_reg    <= OPREAD;
            count_reg      <= '0;
            wr_done_reg    <= 1'b0;
            rd_done_reg    <= 1'b0;
            wr_pending_reg <= 1'b0;
            rd_pending_reg <= 1'b0;
            wr_drop_reg    <= 1'b0;
            rd_drop_reg    <= 1'b0;
            tmo_err_reg    <= 1'b0;
            tmo_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            pg_req_reg     <= pg_req_next;
            optype_reg     <= optype_next;
            addr_reg       <= addr_next;
            last_op_reg    <= last_op_next;
            count_reg      <= count_next;
            wr_done_reg    <= wr_done_next;
            rd_done_reg    <= rd_done_next;
            wr_pending_reg <= wr_pending_next;
            rd_pending_reg <= rd_pending_next;
            wr_drop_reg    <= wr_drop_next;
            rd_drop_reg    <= rd_drop_next;
            tmo_err_reg    <= tmo_err_next;
            tmo_cnt_reg    <= tmo_cnt_next;
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign pg.pg_req      = pg_req_reg;
    assign pg.pg_optype   = optype_reg;
    assign pg.pg_req_addr = addr_reg;

    assign wr_pg_done  = wr_done_reg;
    assign rd_pg_done  = rd_done_reg;
    assign busy        = (state_reg != S_IDLE);
    assign pg_count    = count_reg;
    assign full        = (count_reg == CNT_W'(N_PAGES));
    assign empty       = (count_reg == '0);
    assign wr_drop_err = wr_drop_reg;
    assign rd_drop_err = rd_drop_reg;
    assign timeout_err = tmo_err_reg;

endmodule

// File: tb/tb_ddr3_pg_ring_sequencer.sv
// tb_ddr3_pg_ring_sequencer
// Directed bench for the DDR3 page ring sequencer with a small transfer
// controller model that acks after ack_delay cycles and releases the ack
// ack_hold cycles after pg_req drops. Every issued transfer is logged.
module tb_ddr3_pg_ring_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_pg_req;
    logic       rd_pg_req;
    logic       clear_err;
    logic       wr_pg_done;
    logic       rd_pg_done;
    logic       busy;
    logic [4:0] pg_count;
    logic       full;
    logic       empty;
    logic       wr_drop_err;
    logic       rd_drop_err;
    logic       timeout_err;

    int tests = 0;
    int fails = 0;

    ddr3_pg_ring_sequencer_if pg_bus ();

    ddr3_pg_ring_sequencer #(
        .N_PAGES        (16),
        .BASE_ADDR      (28'h0),
        .PG_ADDR_STRIDE (2048),
        .ACK_TIMEOUT    (65535)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_pg_req   (wr_pg_req),
        .rd_pg_req   (rd_pg_req),
        .clear_err   (clear_err),
        .pg          (pg_bus.master),
        .wr_pg_done  (wr_pg_done),
        .rd_pg_done  (rd_pg_done),
        .busy        (busy),
        .pg_count    (pg_count),
        .full        (full),
        .empty       (empty),
        .wr_drop_err (wr_drop_err),
        .rd_drop_err (rd_drop_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------
    // Transfer controller model (drives on the falling edge)
    // ---------------------------------------------------------------
    int          ack_delay = 2;
    int          ack_hold  = 0;
    int          wait_cnt  = 0;
    bit          req_seen  = 1'b0;
    bit          op_q   [$];
    logic [27:0] addr_q [$];

    always @(negedge clk) begin
        if (rst) begin
            pg_bus.pg_ack = 1'b0;
            wait_cnt      = 0;
            req_seen      = 1'b0;
        end else begin
            if (pg_bus.pg_req && !req_seen) begin
                req_seen = 1'b1;
                op_q.push_back(pg_bus.pg_optype);
                addr_q.push_back(pg_bus.pg_req_addr);
                $display("[TB] txn %s addr=0x%07h count=%0d",
                         pg_bus.pg_optype ? "WRITE" : "READ ", pg_bus.pg_req_addr, pg_count);
            end
            if (!pg_bus.pg_req) req_seen = 1'b0;

            if (pg_bus.pg_ack) begin
                if (!pg_bus.pg_req) begin
                    if (wait_cnt >= ack_hold) begin
                        pg_bus.pg_ack = 1'b0;
                        wait_cnt      = 0;
                    end else begin
                        wait_cnt++;
                    end
                end
            end else if (pg_bus.pg_req) begin
                if (wait_cnt >= ack_delay) begin
                    pg_bus.pg_ack = 1'b1;
                    wait_cnt      = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Helpers
    // ---------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_wr();
        @(negedge clk); wr_pg_req = 1'b1;
        @(negedge clk); wr_pg_req = 1'b0;
    endtask

    task automatic pulse_rd();
        @(negedge clk); rd_pg_req = 1'b1;
        @(negedge clk); rd_pg_req = 1'b0;
    endtask

    task automatic pulse_both();
        @(negedge clk); wr_pg_req = 1'b1; rd_pg_req = 1'b1;
        @(negedge clk); wr_pg_req = 1'b0; rd_pg_req = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear_err = 1'b1;
        @(negedge clk); clear_err = 1'b0;
    endtask

    // Waits (bounded) for a done pulse; an expired budget fails the check.
    task automatic wait_done(input bit rd, input int budget, input string tag);
        int n = 0;
        while (((rd ? rd_pg_done : wr_pg_done) !== 1'b1) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(rd ? rd_pg_done : wr_pg_done), 1);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        op_q.delete();
        addr_q.delete();
    endtask

    // ---------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------
    initial begin
        int n;
        rst       = 1'b1;
        wr_pg_req = 1'b0;
        rd_pg_req = 1'b0;
        clear_err = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_pg_req",   32'(pg_bus.pg_req), 0);
        chk("rst_busy",     32'(busy), 0);
        chk("rst_count",    32'(pg_count), 0);
        chk("rst_empty",    32'(empty), 1);
        chk("rst_full",     32'(full), 0);
        chk("rst_errs",     32'({wr_drop_err, rd_drop_err, timeout_err}), 0);
        chk("rst_done",     32'({wr_pg_done, rd_pg_done}), 0);
        rst = 1'b0;

        // 1: single write, controller acks after 300 cycles
        ack_delay = 300;
        pulse_wr();
        chk("t1_req_not_yet", 32'(pg_bus.pg_req), 0);
        @(negedge clk);
        chk("t1_req_high",  32'(pg_bus.pg_req), 1);
        chk("t1_optype",    32'(pg_bus.pg_optype), 1);
        chk("t1_addr",      32'(pg_bus.pg_req_addr), 32'h0000000);
        chk("t1_busy",      32'(busy), 1);
        wait_done(1'b0, 400, "t1_wr_done");
        chk("t1_count",     32'(pg_count), 1);
        chk("t1_idle",      32'(busy), 0);
        chk("t1_empty",     32'(empty), 0);

        // 2: fill the ring, 17th write waits, a read frees a slot
        ack_delay = 2;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            pulse_wr();
            wait_done(1'b0, 50, "t2_fill_done");
        end
        chk("t2_count16",   32'(pg_count), 16);
        chk("t2_full",      32'(full), 1);
        chk("t2_addr15",    32'(addr_q[15]), 32'h0007800);
        op_q.delete();
        addr_q.delete();
        pulse_wr();
        repeat (20) @(negedge clk);
        chk("t2_17th_held", 32'(pg_bus.pg_req), 0);
        chk("t2_17th_idle", 32'(busy), 0);
        chk("t2_no_drop",   32'(wr_drop_err), 0);
        pulse_rd();
        wait_done(1'b1, 50, "t2_rd_done");
        chk("t2_count15",   32'(pg_count), 15);
        wait_done(1'b0, 50, "t2_wr_done");
        chk("t2_count16b",  32'(pg_count), 16);
        chk("t2_q_size",    32'(op_q.size()), 2);
        chk("t2_rd_op",     32'(op_q[0]), 0);
        chk("t2_rd_addr",   32'(addr_q[0]), 32'h0000000);
        chk("t2_wr_op",     32'(op_q[1]), 1);
        chk("t2_wr_wrap",   32'(addr_q[1]), 32'h0000000);

        // 3: arbitration. 4 writes + 1 read -> count 3, wr_ptr 4, rd_ptr 1, last read
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pulse_wr();
            wait_done(1'b0, 50, "t3_pre_wr");
        end
        pulse_rd();
        wait_done(1'b1, 50, "t3_pre_rd");
        chk("t3_count3",    32'(pg_count), 3);
        op_q.delete();
        addr_q.delete();
        pulse_both();
        wait_done(1'b0, 50, "t3_p1_wr");
        wait_done(1'b1, 50, "t3_p1_rd");
        chk("t3_p1_first_op",  32'(op_q[0]), 1);
        chk("t3_p1_first_adr", 32'(addr_q[0]), 32'h0002000);
        chk("t3_p1_sec_op",    32'(op_q[1]), 0);
        chk("t3_p1_sec_adr",   32'(addr_q[1]), 32'h0000800);
        chk("t3_p1_count",     32'(pg_count), 3);
        // lone write makes the last operation a write
        pulse_wr();
        wait_done(1'b0, 50, "t3_lone_wr");
        op_q.delete();
        addr_q.delete();
        pulse_both();
        wait_done(1'b1, 50, "t3_p2_rd");
        wait_done(1'b0, 50, "t3_p2_wr");
        chk("t3_p2_first_op",  32'(op_q[0]), 0);
        chk("t3_p2_first_adr", 32'(addr_q[0]), 32'h0001000);
        chk("t3_p2_sec_op",    32'(op_q[1]), 1);
        chk("t3_p2_sec_adr",   32'(addr_q[1]), 32'h0003000);
        chk("t3_p2_count",     32'(pg_count), 4);

        // 4: drop errors while a slow read is in flight
        ack_delay = 60;
        op_q.delete();
        addr_q.delete();
        pulse_rd();
        repeat (2) @(negedge clk);
        chk("t4_busy",      32'(busy), 1);
        pulse_wr();
        chk("t4_wr_nodrop", 32'(wr_drop_err), 0);
        pulse_wr();
        chk("t4_wr_drop",   32'(wr_drop_err), 1);
        pulse_rd();
        chk("t4_rd_nodrop", 32'(rd_drop_err), 0);
        pulse_rd();
        chk("t4_rd_drop",   32'(rd_drop_err), 1);
        @(negedge clk); clear_err = 1'b1; wr_pg_req = 1'b1;
        @(negedge clk); clear_err = 1'b0; wr_pg_req = 1'b0;
        chk("t4_drop_beats_clr", 32'(wr_drop_err), 1);
        chk("t4_rd_cleared",     32'(rd_drop_err), 0);
        pulse_clear();
        chk("t4_wr_cleared", 32'(wr_drop_err), 0);
        wait_done(1'b1, 200, "t4_rd_done");
        ack_delay = 2;
        chk("t4_count3",    32'(pg_count), 3);
        wait_done(1'b0, 50, "t4_wr_done");
        wait_done(1'b1, 50, "t4_rd2_done");
        chk("t4_q_size",    32'(op_q.size()), 3);
        chk("t4_adr0",      32'(addr_q[0]), 32'h0001800);
        chk("t4_op1",       32'(op_q[1]), 1);
        chk("t4_adr1",      32'(addr_q[1]), 32'h0003800);
        chk("t4_adr2",      32'(addr_q[2]), 32'h0002000);
        chk("t4_count_end", 32'(pg_count), 3);

        // 5: ack timeout, handshake is kept alive and completes late
        ack_delay = 70000;
        pulse_wr();
        repeat (65000) @(negedge clk);
        chk("t5_tmo_early", 32'(timeout_err), 0);
        repeat (600) @(negedge clk);
        chk("t5_tmo_set",   32'(timeout_err), 1);
        chk("t5_req_held",  32'(pg_bus.pg_req), 1);
        chk("t5_addr",      32'(pg_bus.pg_req_addr), 32'h0004000);
        wait_done(1'b0, 6000, "t5_late_done");
        chk("t5_count",     32'(pg_count), 4);
        chk("t5_sticky",    32'(timeout_err), 1);
        pulse_clear();
        chk("t5_cleared",   32'(timeout_err), 0);

        // 6: reset while the controller still holds ack (S_REL)
        ack_delay = 2;
        ack_hold  = 20;
        pulse_wr();
        n = 0;
        while ((pg_bus.pg_req !== 1'b1) && (n < 50)) begin @(negedge clk); n++; end
        chk("t6_req_rose",  32'(pg_bus.pg_req), 1);
        n = 0;
        while ((pg_bus.pg_req !== 1'b0) && (n < 50)) begin @(negedge clk); n++; end
        chk("t6_in_rel",    32'({pg_bus.pg_req, busy}), 32'h1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_req",   32'(pg_bus.pg_req), 0);
        chk("t6_rst_count", 32'(pg_count), 0);
        chk("t6_rst_busy",  32'(busy), 0);
        chk("t6_rst_done",  32'(wr_pg_done), 0);
        rst       = 1'b0;
        ack_hold  = 0;
        op_q.delete();
        addr_q.delete();
        pulse_wr();
        wait_done(1'b0, 50, "t6_post_wr");
        pulse_rd();
        wait_done(1'b1, 50, "t6_post_rd");
        chk("t6_wr_ptr0",   32'(addr_q[0]), 32'h0000000);
        chk("t6_rd_ptr0",   32'(addr_q[1]), 32'h0000000);
        chk("t6_empty",     32'(empty), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
